// File: rtl/fir_tdm.sv
// fir_tdm: multi-channel FIR filter with a single multiplier and accumulator.
// Each accepted sample walks its channel's delay line against the shared
// coefficient set over TAPS cycles, then is rounded, saturated and presented
// for one cycle on DOUT/VOUT.
module fir_tdm #(
    parameter  int DATA_WIDTH = 13,
    parameter  int COEF_WIDTH = 13,
    parameter  int TAPS       = 9,
    parameter  int CHANNELS   = 2,
    parameter  int OUT_SHIFT  = 12,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int K_W        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         VIN,
    output logic                         READY,
    input  logic signed [DATA_WIDTH-1:0] DIN,
    input  logic        [CH_W-1:0]       CH_IN,
    input  logic                         COEF_WE,
    input  logic        [K_W-1:0]        COEF_ADDR,
    input  logic signed [COEF_WIDTH-1:0] COEF_DATA,
    output logic signed [DATA_WIDTH-1:0] DOUT,
    output logic                         VOUT,
    output logic        [CH_W-1:0]       CH_OUT,
    output logic                         SAT
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    // Sum of TAPS full-precision products can never overflow this width.
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic [K_W-1:0]          K_LAST = K_W'(TAPS - 1);
    // One extra bit above the accumulator absorbs the rounding addend.
    localparam logic signed [ACC_W:0]   ROUND  = (OUT_SHIFT > 0) ?
                                                 (ACC_W+1)'(64'sd1 <<< RND_SH) : '0;
    localparam logic signed [ACC_W:0]   MAX_V  = (ACC_W+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0]   MIN_V  = ~MAX_V;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                        r_state;
    logic                          r_ready;
    logic        [K_W-1:0]         r_k;
    logic        [CH_W-1:0]        r_ch;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [DATA_WIDTH-1:0]  r_x [CHANNELS][TAPS];
    logic signed [COEF_WIDTH-1:0]  r_h [TAPS];
    logic signed [DATA_WIDTH-1:0]  r_dout;
    logic                          r_vout;
    logic        [CH_W-1:0]        r_ch_out;
    logic                          r_sat;

    logic                          w_accept;
    logic                          w_ch_ok;
    logic                          w_addr_ok;
    logic signed [DATA_WIDTH-1:0]  w_x_tap;
    logic signed [COEF_WIDTH-1:0]  w_h_tap;
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [ACC_W:0]         w_rnd;
    logic signed [ACC_W:0]         w_shf;
    logic signed [DATA_WIDTH-1:0]  w_dout_nx;
    logic                          w_sat_nx;

    assign w_accept  = VIN && r_ready;
    assign w_addr_ok = (COEF_ADDR <= K_LAST);

    // Channel number is legal only if it names one of the instantiated delay lines.
    always_comb begin
        w_ch_ok = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CH_IN == CH_W'(c)) w_ch_ok = 1'b1;
        end
    end

    // Single shared multiplier, fed by the tap counter.
    assign w_x_tap = r_x[r_ch][r_k];
    assign w_h_tap = r_h[r_k];
    assign w_prod  = w_x_tap * w_h_tap;

    // Round half up, arithmetic shift, then clamp to the output range.
    assign w_rnd = (ACC_W+1)'(r_acc) + ROUND;
    assign w_shf = w_rnd >>> OUT_SHIFT;

    // Saturation decision on the shifted accumulator.
    always_comb begin
        w_sat_nx  = 1'b0;
        w_dout_nx = w_shf[DATA_WIDTH-1:0];
        if (w_shf > MAX_V) begin
            w_sat_nx  = 1'b1;
            w_dout_nx = MAX_V[DATA_WIDTH-1:0];
        end else if (w_shf < MIN_V) begin
            w_sat_nx  = 1'b1;
            w_dout_nx = MIN_V[DATA_WIDTH-1:0];
        end
    end

    // Control FSM, delay lines, coefficient store, accumulator and output registers.
    // NOTE: all state here uses non-blocking assignments so every register sees
    // the pre-edge values of the others, which is what makes the shift register shift.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_k      <= '0;
            r_ch     <= '0;
            r_acc    <= '0;
            r_dout   <= '0;
            r_vout   <= 1'b0;
            r_ch_out <= '0;
            r_sat    <= 1'b0;
            // NOTE: delay lines and coefficients must come out of reset as zero,
            // so they are built as resettable flops rather than an inferred RAM.
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_x[c][k] <= '0;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                r_h[k] <= '0;
            end
        end else begin
            r_vout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // A sample for a non-existent channel is consumed silently.
                        if (w_ch_ok) begin
                            for (int k = TAPS - 1; k > 0; k--) begin
                                r_x[CH_IN][k] <= r_x[CH_IN][k-1];
                            end
                            r_x[CH_IN][0] <= DIN;
                            r_ch    <= CH_IN;
                            r_k     <= '0;
                            r_acc   <= '0;
                            r_ready <= 1'b0;
                            r_state <= S_MAC;
                        end
                    end else if (COEF_WE && w_addr_ok) begin
                        r_h[COEF_ADDR] <= COEF_DATA;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_k == K_LAST) begin
                        r_state <= S_OUT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_OUT: begin
                    r_dout   <= w_dout_nx;
                    r_sat    <= w_sat_nx;
                    r_ch_out <= r_ch;
                    r_vout   <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign READY  = r_ready;
    assign DOUT   = r_dout;
    assign VOUT   = r_vout;
    assign CH_OUT = r_ch_out;
    assign SAT    = r_sat;

endmodule

// File: tb/tb_fir_tdm.sv
// tb_fir_tdm: table vectors for the impulse/isolation cases, hand sequences for
// saturation, backpressure, abort and coefficient-write corners, and a random
// run checked against an arithmetic reference model of the filter.
module tb_fir_tdm;

    localparam int DW        = 13;
    localparam int CW        = 13;
    localparam int TAPS      = 9;
    localparam int CHANNELS  = 2;
    localparam int OUT_SHIFT = 12;
    localparam int CH_W      = 1;
    localparam int K_W       = 4;
    localparam int LAT       = TAPS + 1;
    localparam int PERIOD    = TAPS + 2;
    localparam int HI        = (1 <<< (DW - 1)) - 1;
    localparam int LO        = -(1 <<< (DW - 1));

    logic                  CLK;
    logic                  RST;
    logic                  VIN;
    logic                  READY;
    logic signed [DW-1:0]  DIN;
    logic [CH_W-1:0]       CH_IN;
    logic                  COEF_WE;
    logic [K_W-1:0]        COEF_ADDR;
    logic signed [CW-1:0]  COEF_DATA;
    logic signed [DW-1:0]  DOUT;
    logic                  VOUT;
    logic [CH_W-1:0]       CH_OUT;
    logic                  SAT;

    fir_tdm #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS),
        .CHANNELS(CHANNELS), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .CLK(CLK), .RST(RST), .VIN(VIN), .READY(READY), .DIN(DIN),
        .CH_IN(CH_IN), .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR),
        .COEF_DATA(COEF_DATA), .DOUT(DOUT), .VOUT(VOUT), .CH_OUT(CH_OUT),
        .SAT(SAT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   cyc = 0;
    logic rst_q;
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int ch;
        int dout;
        int sat;
        int acc_cyc;
    } exp_t;

    int   h_m [TAPS];
    int   x_m [CHANNELS][TAPS];
    exp_t exp_q [$];

    function automatic void model_clear();
        for (int k = 0; k < TAPS; k++) begin
            h_m[k] = 0;
            for (int c = 0; c < CHANNELS; c++) x_m[c][k] = 0;
        end
        exp_q.delete();
    endfunction

    // y = sum h[k]*x[n-k], rounded half up, shifted, clamped.
    function automatic void model_out(input int ch, output int dout, output int sat);
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(h_m[k]) * longint'(x_m[ch][k]);
        if (OUT_SHIFT > 0) s += longint'(1) <<< (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0);
        s = s >>> OUT_SHIFT;
        sat = 0;
        if (s > HI)      begin dout = HI; sat = 1; end
        else if (s < LO) begin dout = LO; sat = 1; end
        else             dout = int'(s);
    endfunction

    function automatic void model_accept(input int ch, input int din);
        exp_t e;
        if (ch >= CHANNELS) return;
        for (int k = TAPS - 1; k > 0; k--) x_m[ch][k] = x_m[ch][k-1];
        x_m[ch][0] = din;
        e.ch = ch;
        model_out(ch, e.dout, e.sat);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
    endfunction

    // ---------------- output monitor ----------------
    int last_dout = 0;
    int last_ch   = 0;
    int last_sat  = 0;

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (rst_q) begin
                check("rst_vout", VOUT, 0);
                check("rst_dout", DOUT, 0);
                check("rst_ch_out", CH_OUT, 0);
                check("rst_sat", SAT, 0);
                check("rst_ready", READY, 1);
                last_dout = 0; last_ch = 0; last_sat = 0;
            end else if (VOUT) begin
                if (exp_q.size() == 0) begin
                    check("vout_unexpected", VOUT, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_dout", DOUT, e.dout);
                    check("mon_ch_out", CH_OUT, e.ch);
                    check("mon_sat", SAT, e.sat);
                    check("mon_latency", cyc - e.acc_cyc, LAT);
                    last_dout = e.dout; last_ch = e.ch; last_sat = e.sat;
                end
            end else begin
                check("hold_dout", DOUT, last_dout);
                check("hold_ch_out", CH_OUT, last_ch);
                check("hold_sat", SAT, last_sat);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_clear();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!READY && n < 50) begin tick(); n++; end
        if (!READY) check("ready_timeout", READY, 1);
    endtask

    task automatic send(input int ch, input int din);
        wait_ready();
        VIN   = 1'b1;
        DIN   = DW'(din);
        CH_IN = CH_W'(ch);
        tick();
        model_accept(ch, din);
        VIN   = 1'b0;
    endtask

    // Returns the number of edges from acceptance to the VOUT cycle.
    task automatic wait_vout(output int n);
        n = 0;
        while (!VOUT && n < 40) begin tick(); n++; end
        if (!VOUT) check("vout_timeout", VOUT, 1);
    endtask

    task automatic write_coef(input int addr, input int data);
        bit take;
        take      = READY && !VIN;
        COEF_WE   = 1'b1;
        COEF_ADDR = K_W'(addr);
        COEF_DATA = CW'(data);
        tick();
        COEF_WE   = 1'b0;
        if (take) h_m[addr] = data;
    endtask

    task automatic load_impulse_coefs();
        for (int k = 0; k < TAPS; k++) begin
            wait_ready();
            write_coef(k, k + 1);
        end
    endtask

    typedef struct {
        int ch;
        int din;
        int dout;
        int ch_out;
        int sat;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        send(v.ch, v.din);
        wait_vout(n);
        check({tag, "_latency"}, n, LAT);
        check({tag, "_dout"}, DOUT, v.dout);
        check({tag, "_ch_out"}, CH_OUT, v.ch_out);
        check({tag, "_sat"}, SAT, v.sat);
    endtask

    task automatic send_wait(input int ch, input int din);
        int n;
        send(ch, din);
        wait_vout(n);
    endtask

    // ---------------- test sequence ----------------
    vec_t imp_v [TAPS];
    vec_t iso_v [2*TAPS];

    initial begin
        int n;
        int cnt;
        int prev;
        int n_acc;
        bit rdy;

        // 4095 is the largest representable 13-bit sample; with h[k]=k+1 it still
        // rounds to exactly k+1 at every tap (4095*m + 2048 >> 12 == m for m<=9).
        for (int i = 0; i < TAPS; i++) begin
            imp_v[i]       = '{ch: 0, din: (i == 0) ? 4095 : 0, dout: i + 1, ch_out: 0, sat: 0};
            iso_v[2*i]     = '{ch: 0, din: (i == 0) ? 4095 : 0, dout: i + 1, ch_out: 0, sat: 0};
            iso_v[2*i + 1] = '{ch: 1, din: 0, dout: 0, ch_out: 1, sat: 0};
        end

        RST = 1'b1; VIN = 1'b0; DIN = '0; CH_IN = '0;
        COEF_WE = 1'b0; COEF_ADDR = '0; COEF_DATA = '0;
        tick(); tick();
        RST = 1'b0;
        model_clear();
        check("init_ready", READY, 1);
        check("init_dout", DOUT, 0);

        // Impulse response on channel 0.
        load_impulse_coefs();
        for (int i = 0; i < TAPS; i++) run_vec(imp_v[i], "impulse");

        // Channel isolation: ch0 impulse interleaved with ch1 zeros.
        do_reset();
        load_impulse_coefs();
        for (int i = 0; i < 2*TAPS; i++) run_vec(iso_v[i], "isolation");

        // Saturation in both directions.
        do_reset();
        for (int k = 0; k < TAPS; k++) begin wait_ready(); write_coef(k, 4095); end
        for (int i = 0; i < TAPS; i++) send_wait(0, 4095);
        check("sat_pos_dout", DOUT, 4095);
        check("sat_pos_flag", SAT, 1);
        for (int i = 0; i < TAPS; i++) send_wait(0, -4096);
        check("sat_neg_dout", DOUT, -4096);
        check("sat_neg_flag", SAT, 1);

        // Backpressure: VIN held high, one acceptance per PERIOD cycles.
        wait_ready();
        VIN = 1'b1; DIN = '0; CH_IN = '0;
        prev = -1; n_acc = 0;
        for (int i = 0; i < 60; i++) begin
            rdy = READY;
            tick();
            if (rdy) begin
                model_accept(0, 0);
                if (prev >= 0) check("bp_interval", cyc - prev, PERIOD);
                prev = cyc;
                n_acc++;
            end
        end
        VIN = 1'b0;
        check("bp_count", n_acc, 6);

        // Coefficient write while busy is dropped.
        do_reset();
        load_impulse_coefs();
        send(0, 0);
        check("busy_ready_low", READY, 0);
        write_coef(0, 100);
        wait_vout(n);
        run_vec(imp_v[0], "coef_busy");

        // Coefficient write in the same cycle as an acceptance is dropped too.
        wait_ready();
        VIN = 1'b1; DIN = '0; CH_IN = '0;
        write_coef(0, 100);
        model_accept(0, 0);
        VIN = 1'b0;
        wait_vout(n);
        for (int i = 0; i < TAPS; i++) send_wait(0, 0);
        run_vec(imp_v[0], "coef_accept");

        // Reset in MAC cycle 4 aborts; coefficients come back as zero.
        do_reset();
        load_impulse_coefs();
        send(0, 4095);
        tick(); tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_clear();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (VOUT) cnt++; end
        check("abort_no_vout", cnt, 0);
        for (int i = 0; i < TAPS; i++) begin
            send_wait(0, (i == 0) ? 4095 : 0);
            check("abort_zero_coef_dout", DOUT, 0);
        end
        load_impulse_coefs();
        for (int i = 0; i < TAPS; i++) run_vec(imp_v[i], "abort_reload");

        // Random traffic against the reference model.
        do_reset();
        for (int k = 0; k < TAPS; k++) begin
            wait_ready();
            write_coef(k, int'($urandom_range(511)) - 256);
        end
        for (int i = 0; i < 120; i++) begin
            if (i == 60) begin
                for (int k = 0; k < TAPS; k++) begin
                    wait_ready();
                    write_coef(k, int'($urandom_range(8191)) - 4096);
                end
            end
            send(int'($urandom_range(CHANNELS - 1)), int'($urandom_range(8191)) - 4096);
            cnt = int'($urandom_range(12));
            for (int j = 0; j < cnt; j++) tick();
            if ($urandom_range(3) == 0)
                write_coef(int'($urandom_range(TAPS - 1)),
                           (i < 60) ? int'($urandom_range(511)) - 256
                                    : int'($urandom_range(8191)) - 4096);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        check("drain_empty", exp_q.size(), 0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
